// File: rtl/jk_count_seq.sv
// Command sequencer for a bank of JK flip-flop cells: computes per-cell J/K
// excitation from bank feedback and tracks the expected bank state.
module jk_count_seq #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [7:0]       steps,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {CMD_UP, CMD_DOWN, CMD_LOAD, CMD_CLR} cmd_t;

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);

  state_t           state, state_nx;
  cmd_t             cmd_mode;
  logic [WIDTH-1:0] cmd_val;
  logic [7:0]       remaining;
  logic [WIDTH-1:0] exp_q;
  logic             exp_valid;
  logic             tc_q;
  logic             err_q;
  logic [WIDTH-1:0] nxt;
  logic             wrap;

  // Next bank value is derived from live feedback, not from exp_q, so the
  // sequencer re-synchronises to whatever the bank actually holds.
  always_comb begin
    nxt  = '0;
    wrap = 1'b0;
    case (cmd_mode)
      CMD_UP: begin
        nxt  = (q_fb >= MAXV) ? '0 : q_fb + 1'b1;
        wrap = (q_fb == MAXV);
      end
      CMD_DOWN: begin
        nxt  = (q_fb == '0 || q_fb > MAXV) ? MAXV : q_fb - 1'b1;
        wrap = (q_fb == '0);
      end
      CMD_LOAD: nxt = cmd_val;
      default:  nxt = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    j        = '0;
    k        = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (mode[1] || steps != 8'd0) state_nx = RUN;
          else                          state_nx = DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        j    = ~q_fb & nxt;
        k    = q_fb & ~nxt;
        if (remaining == 8'd1) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_mode  <= CMD_UP;
      cmd_val   <= '0;
      remaining <= '0;
      exp_q     <= '0;
      exp_valid <= 1'b0;
      tc_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      tc_q  <= 1'b0;
      case (state)
        IDLE: begin
          exp_valid <= 1'b0;
          if (start) begin
            cmd_mode  <= cmd_t'(mode);
            cmd_val   <= load_val;
            err_q     <= 1'b0;
            remaining <= mode[1] ? 8'd1 : steps;
          end
        end
        RUN: begin
          remaining <= remaining - 8'd1;
          exp_q     <= nxt;
          exp_valid <= 1'b1;
          tc_q      <= wrap;
          if ((exp_valid && q_fb != exp_q) || q_fb > MAXV) err_q <= 1'b1;
        end
        DONE: begin
          if (exp_valid && q_fb != exp_q) err_q <= 1'b1;
          exp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign tc  = tc_q;
  assign err = err_q;

endmodule

// File: tb/tb_jk_count_seq.sv
// Bench for jk_count_seq: a behavioural JK bank closes the feedback loop and
// a scoreboard queue holds the expected excitation / bank / wrap per edge.
module tb_jk_count_seq;

  localparam int unsigned W   = 4;
  localparam int unsigned MAX = 9;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] load_val;
  logic [7:0]   steps;
  logic [W-1:0] q_fb;
  logic [W-1:0] j, k;
  logic         busy, done, tc, err;

  logic [W-1:0] bank;
  logic         preset_en = 1'b0;
  logic [W-1:0] preset_val = '0;
  logic         fault_en = 1'b0;
  logic [W-1:0] fault_val = '0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [W-1:0] jj;
    logic [W-1:0] kk;
    logic [W-1:0] nx;
    logic         wrap;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Behavioural JK cell bank; not touched by the sequencer's reset.
  always @(posedge clk) begin
    if (preset_en) bank <= preset_val;
    else           bank <= (j & ~bank) | (~k & bank);
  end

  assign q_fb = fault_en ? fault_val : bank;

  jk_count_seq #(.WIDTH(W), .MAX_COUNT(MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .load_val(load_val), .steps(steps), .q_fb(q_fb),
    .j(j), .k(k), .busy(busy), .done(done), .tc(tc), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_next(input logic [1:0] m, input logic [W-1:0] q,
                                            input logic [W-1:0] lv);
    case (m)
      2'd0:    return (q >= W'(MAX)) ? W'(0) : W'(q + 1);
      2'd1:    return (q == 0 || q > W'(MAX)) ? W'(MAX) : W'(q - 1);
      2'd2:    return lv;
      default: return W'(0);
    endcase
  endfunction

  task automatic preset(input logic [W-1:0] v);
    preset_en  = 1'b1;
    preset_val = v;
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  // Caller is at a negedge with the DUT idle.
  task automatic run_cmd(input logic [1:0] m, input logic [W-1:0] lv,
                         input logic [7:0] n, input bit intrude);
    logic [W-1:0] qb;
    logic [W-1:0] start_bank;
    int cnt;
    exp_t e;
    qb = bank;
    start_bank = bank;
    cnt = m[1] ? 1 : int'(n);
    for (int i = 0; i < cnt; i++) begin
      e.nx   = ref_next(m, qb, lv);
      e.jj   = ~qb & e.nx;
      e.kk   = qb & ~e.nx;
      e.wrap = (m == 2'd0 && qb == W'(MAX)) || (m == 2'd1 && qb == 0);
      sb.push_back(e);
      qb = e.nx;
    end
    start = 1'b1; mode = m; load_val = lv; steps = n;
    @(negedge clk);
    start = 1'b0;
    if (cnt == 0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_bank", bank, start_bank);
      @(negedge clk);
      check("zero_idle", done, 0);
      check("zero_busy2", busy, 0);
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_err", err, 0);
      e = sb.pop_front();
      check("run_j", j, e.jj);
      check("run_k", k, e.kk);
      if (intrude && i == 0) begin
        start = 1'b1; mode = ~m; load_val = ~lv; steps = 8'd200;
      end
      @(negedge clk);
      start = 1'b0;
      check("bank", bank, e.nx);
      check("tc", tc, e.wrap);
    end
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_jk", {j, k}, 0);
    check("end_err", err, 0);
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_tc", tc, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = '0; load_val = '0; steps = '0;
    bank = '0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tcerr", {tc, err}, 0);
    check("rst_jk", {j, k}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of an up-count.
    preset(4'd0);
    start = 1'b1; mode = 2'd0; steps = 8'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_bank", bank, 2);
    #2 reset = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_tcerr", {tc, err}, 0);
    check("mid_jk", {j, k}, 0);
    @(negedge clk);
    check("mid_hold", bank, 2);
    reset = 1'b0;
    @(negedge clk);

    preset(4'd0);
    run_cmd(2'd0, 4'd0, 8'd12, 1'b0);
    check("up12_bank", bank, 2);

    preset(4'd1);
    start = 1'b1; mode = 2'd1; steps = 8'd3;
    @(negedge clk);
    start = 1'b0;
    check("dn_j10", j, 4'b0000);
    check("dn_k10", k, 4'b0001);
    repeat (4) @(negedge clk);
    check("dn_bank", bank, 8);
    @(negedge clk);
    preset(4'd1);
    run_cmd(2'd1, 4'd0, 8'd3, 1'b0);

    preset(4'b1001);
    run_cmd(2'd2, 4'b0110, 8'd0, 1'b0);
    check("load_bank", bank, 4'b0110);
    run_cmd(2'd3, 4'b1111, 8'd7, 1'b0);
    check("clr_bank", bank, 0);

    preset(4'd7);
    run_cmd(2'd0, 4'd0, 8'd0, 1'b0);
    run_cmd(2'd0, 4'd0, 8'd3, 1'b1);
    check("intr_bank", bank, 0);

    // Feedback disagrees with the expected state mid-run.
    preset(4'd0);
    start = 1'b1; mode = 2'd0; steps = 8'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("flt_pre", err, 0);
    fault_en = 1'b1; fault_val = 4'b0011;
    @(negedge clk);
    fault_en = 1'b0;
    check("flt_err", err, 1);
    @(negedge clk);
    check("flt_done", done, 1);
    check("flt_err_done", err, 1);
    @(negedge clk);
    check("flt_err_idle", err, 1);
    @(negedge clk);
    check("flt_err_idle2", err, 1);
    run_cmd(2'd0, 4'd0, 8'd1, 1'b0);

    // Out-of-range feedback.
    preset(4'd0);
    start = 1'b1; mode = 2'd0; steps = 8'd3;
    @(negedge clk);
    start = 1'b0;
    fault_en = 1'b1; fault_val = 4'b1100;
    @(negedge clk);
    fault_en = 1'b0;
    check("oor_err", err, 1);
    repeat (2) @(negedge clk);
    check("oor_done", done, 1);
    check("oor_err_done", err, 1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
